load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Multi-cycle memory-access stage for the RV32I core.
- Sits between the control unit's EXECUTE_S3 (which produces the effective address in alu_out) and WRITEBACK_S4 (which consumes load results).
- Handles byte/half/word loads and stores with lane steering, byte enables and sign/zero extension.
- Drives a req/ack data-memory handshake.
- Reports completion or fault so the control unit can stall in EXECUTE_S3 until done.

Parameters:
- TIMEOUT_CYCLES, 16: maximum cycles mem_req may stay high without mem_ack before a fault; minimum 2.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request from the control unit
- is_load  in  1  operation is a load (LB/LH/LW/LBU/LHU)
- is_store  in  1  operation is a store (SB/SH/SW)
- funct3  in  3  RV32I width/sign code
- addr  in  32  effective byte address (ALU output)
- store_data  in  32  rs2 value
- busy  out  1  operation in flight; start is ignored while high
- done  out  1  one-cycle completion pulse
- fault  out  1  valid only with done: misaligned, illegal, or timeout
- load_data  out  32  extended load result
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_be  out  4  byte enables
- mem_ack  in  1  memory accepts or returns data this cycle
- mem_rdata  in  32  read word, valid when mem_ack=1 on a read

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; timeout counter 0.
- Reset is synchronous and overrides everything, including mid-access: the FSM returns to IDLE and mem_req drops on the next edge.
- FSM states are IDLE, ACCESS and RESP.
- IDLE: start=1 latches addr, store_data, funct3, is_load and is_store.
  - Legal and aligned → ACCESS.
  - Otherwise → RESP with fault=1; no memory request is issued.
- Illegal requests (go to RESP with fault):
  - is_load and is_store both 1, or both 0.
  - funct3 not in {000,001,010,100,101} for a load.
  - funct3 not in {000,001,010} for a store.
- Misaligned requests (go to RESP with fault):
  - Half access with addr[0]=1.
  - Word access with addr[1:0]≠00.
- ACCESS:
  - mem_req=1; mem_we, mem_addr, mem_wdata and mem_be are stable from the latched values.
  - mem_ack=1 → RESP. On a load, capture the extracted result into load_data on the same edge.
  - Each cycle without ack increments the counter. When the counter reaches TIMEOUT_CYCLES-1 with no ack → RESP with fault=1; load_data is unchanged.
- RESP: done=1 for exactly one cycle; fault per the cases above; → IDLE. The counter clears.
- busy=1 in ACCESS and RESP. start=1 in any state other than IDLE is ignored (no queueing).
- Latency: start accepted at cycle 0 → mem_req at cycle 1. With ack at cycle k ≥ 1, done is at cycle k+1. The minimum start→done is 2 cycles; a faulting start gives done at cycle 1.
- Store steering (o = addr[1:0]):
  - SB: wdata = {4{sd[7:0]}}, be = 4'b0001 << o.
  - SH: wdata = {2{sd[15:0]}}, be = 4'b0011 << o.
  - SW: wdata = sd, be = 4'b1111.
- Loads: mem_we=0 and mem_be=4'b1111.
- Load extraction: lane = mem_rdata >> (8*o).
  - LB: sign-extend bits [7:0]; LBU: zero-extend bits [7:0].
  - LH: sign-extend bits [15:0]; LHU: zero-extend bits [15:0].
  - LW: the full word.
- load_data holds its value until the next successful load completes; stores and faults never modify it.
- mem_ack while not in ACCESS is ignored.
- Back-to-back operation: start may be accepted in the IDLE cycle immediately after RESP.

Test Plan:
- Reset, then LW at addr 0x100 with mem_ack on the first mem_req cycle, mem_rdata=0xDEADBEEF → mem_addr=0x100, be=1111, done at cycle 2, load_data=0xDEADBEEF, fault=0.
- LB at 0x103, rdata=0x80112233 → load_data=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x00008011.
- SB at 0x201, store_data=0x000000A5 → mem_we=1, mem_addr=0x200, be=0010, wdata=0xA5A5A5A5. SH at 0x202 with sd=0x1234 → be=1100, wdata=0x12341234.
- LW at 0x102, SH at 0x301, and is_load=is_store=1 → each gives done at cycle 1 with fault=1, mem_req never asserted, load_data unchanged.
- TIMEOUT_CYCLES=4 with ack never asserted → mem_req high for 4 cycles, done+fault in the next cycle. A start pulsed during the wait is ignored.
- rst asserted during ACCESS with ack low → mem_req=0 and busy=0 after that edge, no done pulse. A new LW afterwards completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit for the RV32I core's memory stage.
// Accepts one byte/half/word access per start pulse, checks it for legality
// and alignment, runs a req/ack handshake with data memory (bounded by a
// timeout), and reports completion via a one-cycle done pulse with fault.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, sd_q;
  logic [2:0]    f3_q;
  logic          we_q;
  logic          fault_q, fault_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   ld_q, ld_d;

  // Request decode on the live inputs; only consulted in IDLE with start=1.
  logic ld_ok, st_ok, legal, misal, accept;
  assign ld_ok  = is_load & ~is_store &
                  (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010 ||
                   funct3 == 3'b100 || funct3 == 3'b101);
  assign st_ok  = is_store & ~is_load &
                  (funct3 == 3'b000 || funct3 == 3'b001 || funct3 == 3'b010);
  assign legal  = ld_ok | st_ok;
  assign misal  = ((funct3[1:0] == 2'b01) & addr[0]) |
                  ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign accept = (state_q == IDLE) & start;

  // Capture the request operands when a start is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      sd_q   <= '0;
      f3_q   <= '0;
      we_q   <= 1'b0;
    end else if (accept) begin
      addr_q <= addr;
      sd_q   <= store_data;
      f3_q   <= funct3;
      we_q   <= is_store;
    end
  end

  // Store lane steering: replicate data across lanes, enable the target bytes.
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  always_comb begin
    st_wdata = sd_q;
    st_be    = 4'b1111;
    case (f3_q[1:0])
      2'b00: begin
        st_wdata = {4{sd_q[7:0]}};
        st_be    = 4'b0001 << addr_q[1:0];
      end
      2'b01: begin
        st_wdata = {2{sd_q[15:0]}};
        st_be    = 4'b0011 << addr_q[1:0];
      end
      default: begin
        st_wdata = sd_q;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Load extraction: shift the addressed lane down, then sign/zero extend.
  logic [31:0] lane, ld_ext;
  assign lane = mem_rdata >> {addr_q[1:0], 3'b000};
  always_comb begin
    ld_ext = mem_rdata;
    case (f3_q)
      3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_ext = {24'b0, lane[7:0]};
      3'b101:  ld_ext = {16'b0, lane[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  // State, fault flag, timeout counter and load result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      fault_q <= 1'b0;
      cnt_q   <= '0;
      ld_q    <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
      ld_q    <= ld_d;
    end
  end

  // Next-state logic: bad requests skip memory entirely and fault in RESP.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    ld_d    = ld_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) begin
          if (legal && !misal) begin
            state_d = ACCESS;
            fault_d = 1'b0;
          end else begin
            state_d = RESP;
            fault_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d = RESP;
          fault_d = 1'b0;
          if (!we_q) ld_d = ld_ext;
        end else if (cnt_q == CNT_MAX) begin
          state_d = RESP;
          fault_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        fault_d = 1'b0;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        fault_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from state; memory fields are zero outside ACCESS.
  logic in_acc;
  assign in_acc    = (state_q == ACCESS);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == RESP);
  assign fault     = done & fault_q;
  assign load_data = ld_q;
  assign mem_req   = in_acc;
  assign mem_we    = in_acc & we_q;
  assign mem_addr  = in_acc ? {addr_q[31:2], 2'b00} : 32'h0;
  assign mem_wdata = (in_acc & we_q) ? st_wdata : 32'h0;
  assign mem_be    = in_acc ? (we_q ? st_be : 4'b1111) : 4'b0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a driver issues random and directed
// operations and plays the memory; monitors compare requests and responses
// against expectations computed from a plain behavioural model.
module tb_load_store_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, start, is_load, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        busy, done, fault;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .busy(busy),
    .done(done), .fault(fault), .load_data(load_data), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct { bit flt; logic [31:0] ld; } rsp_t;
  typedef struct { bit we; logic [31:0] a; logic [31:0] wd; logic [3:0] be; } req_t;

  rsp_t rsp_q[$];
  req_t req_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_ld = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: the architectural meaning of one request.
  function automatic void model(input bit ld, input bit st, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] sd,
                                input logic [31:0] rd, output bit bad,
                                output logic [3:0] be, output logic [31:0] wd,
                                output logic [31:0] val);
    int o, nb;
    bit legal;
    logic [31:0] m, v;
    o  = int'(a % 4);
    nb = 1 << f3[1:0];
    legal = (ld != st) && (ld ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
                              : (f3 inside {3'd0, 3'd1, 3'd2}));
    bad = !legal || ((a % nb) != 0);
    be  = ld ? 4'hF : 4'(((1 << nb) - 1) << o);
    wd  = (nb == 1) ? sd[7:0] * 32'h01010101 :
          (nb == 2) ? sd[15:0] * 32'h00010001 : sd;
    if (nb == 4) val = rd;
    else begin
      m = (nb == 1) ? 32'hFF : 32'hFFFF;
      v = (rd >> (8 * o)) & m;
      if (!f3[2] && v > (m >> 1)) v = v - (m + 1);
      val = v;
    end
  endfunction

  // Response monitor: every done pulse must match the oldest expectation.
  always begin
    @(negedge clk); #2;
    if (done) begin
      if (rsp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_done: got done=1 expected none");
      end else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("fault", {31'b0, fault}, {31'b0, r.flt});
        chk("load_data", load_data, r.ld);
      end
    end
  end

  // Request monitor: each accepted memory transfer must match the model.
  always begin
    @(negedge clk); #2;
    if (mem_req && mem_ack) begin
      if (req_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_req: got addr=%h expected none", mem_addr);
      end else begin
        req_t q;
        q = req_q.pop_front();
        chk("mem_we", {31'b0, mem_we}, {31'b0, q.we});
        chk("mem_addr", mem_addr, q.a);
        chk("mem_be", {28'b0, mem_be}, {28'b0, q.be});
        if (q.we) chk("mem_wdata", mem_wdata, q.wd);
      end
    end
  end

  // Driver: issue one op, play memory acking in cycle dly+1 (none if dly>=TO).
  task automatic do_op(input bit ld, input bit st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd,
                       input int dly, input logic [31:0] rd);
    bit bad, to;
    logic [3:0] be;
    logic [31:0] wd, val;
    int k, exp_done, got, reqcnt;
    rsp_t r;
    req_t q;
    model(ld, st, f3, a, sd, rd, bad, be, wd, val);
    to = !bad && dly >= TO;
    k  = dly + 1;
    if (!bad && !to && ld) model_ld = val;
    r.flt = bad || to; r.ld = model_ld;
    rsp_q.push_back(r);
    if (!bad && !to) begin
      q.we = st; q.a = {a[31:2], 2'b00}; q.wd = wd; q.be = be;
      req_q.push_back(q);
    end
    exp_done = bad ? 1 : (to ? TO + 1 : k + 1);
    @(negedge clk);
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a;
    store_data = sd; mem_ack = 1'($urandom % 2); mem_rdata = $urandom;
    got = 0; reqcnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_req) reqcnt++;
      if (done) begin
        got = c;
        mem_ack = 1'($urandom % 2);
        start = 1'($urandom % 2);
        is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0;
        break;
      end
      mem_ack   = !bad && !to && c == k;
      mem_rdata = mem_ack ? rd : $urandom;
      start     = ($urandom % 4) == 0;
      is_load   = 1'($urandom); is_store = 1'($urandom);
      funct3    = 3'($urandom); addr = $urandom; store_data = $urandom;
    end
    chk("done_cycle", 32'(got), 32'(exp_done));
    chk("req_cycles", 32'(reqcnt), bad ? 32'd0 : (to ? 32'(TO) : 32'(k)));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = '0;
    addr = '0; store_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_ld = 32'h0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = '0;
    addr = '0; store_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_be", {28'b0, mem_be}, 32'd0);
    rst = 1'b0;

    // Directed cases.
    do_op(1, 0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF);
    do_op(1, 0, 3'b000, 32'h103, 32'h0, 0, 32'h80112233);
    do_op(1, 0, 3'b100, 32'h103, 32'h0, 1, 32'h80112233);
    do_op(1, 0, 3'b101, 32'h102, 32'h0, 2, 32'h80112233);
    do_op(0, 1, 3'b000, 32'h201, 32'h000000A5, 0, 32'h0);
    do_op(0, 1, 3'b001, 32'h202, 32'h00001234, 0, 32'h0);
    do_op(1, 0, 3'b010, 32'h102, 32'h0, 0, 32'h0);
    do_op(0, 1, 3'b001, 32'h301, 32'h0, 0, 32'h0);
    do_op(1, 1, 3'b010, 32'h100, 32'h0, 0, 32'h0);
    do_op(1, 0, 3'b010, 32'h104, 32'h0, TO, 32'h0);

    // Reset in the middle of an access: no done, request drops at once.
    @(negedge clk);
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    addr = 32'h40; mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("midrst_req_before", {31'b0, mem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_req", {31'b0, mem_req}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    model_ld = 32'h0;
    do_op(1, 0, 3'b010, 32'h40, 32'h0, 1, 32'h13572468);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      int sel, d;
      bit ld, st;
      logic [31:0] a;
      sel = int'($urandom % 8);
      ld = (sel == 0) || (sel >= 2 && sel < 5);
      st = (sel == 0) || (sel >= 5);
      a  = $urandom;
      if ($urandom % 2) a[1:0] = 2'b00;
      d  = ($urandom % 10 < 8) ? int'($urandom % 3) : TO;
      do_op(ld, st, 3'($urandom), a, $urandom, d, $urandom);
      if (i == 150) do_reset();
    end

    repeat (3) @(negedge clk);
    if (rsp_q.size() != 0 || req_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL leftover: got %0d/%0d pending expected 0", rsp_q.size(), req_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
